pe_array_ctrl: RTL and testbench
================================

// Module: pe_array_ctrl
// PURPOSE
// Column sequencer driving a column of NUM_ROWS process-element tiles: it issues
// the per-cycle wire_connection / output_en commands and bus operands the tiles
// consume, then drains the column's results from the bottom tile. It sits between
// the operand streams (valid/ready) and the PE column.
// One job = load, K MAC steps, format, drain NUM_ROWS results.
// PARAMETERS
// WIDTH_DATA  16  operand / result width
// NUM_ROWS    4   PE tiles in the column = results drained per job
// WIDTH_CNT   8   width of MAC-step count k_len_i
// FMT_CYCLES  2   cycles wire_connection=3 is held before drain
// PIPE_LAT    2   cycles from command change at port to bot_data_i reflecting it
// PORTS
// clk                  in   1          clock
// rst_n                in   1          async active-low reset
// start_i              in   1          job request, sampled in IDLE only
// k_len_i              in   WIDTH_CNT  MAC steps for job, sampled with start_i
// busy_o               out  1          high from accepted start until done_o
// done_o               out  1          1-cycle pulse, job complete
// a_data_i/a_valid_i   in   WD/1       v_bus operand stream
// a_ready_o            out  1          a handshake ready
// b_data_i/b_valid_i   in   WD/1       h_bus operand stream
// b_ready_o            out  1          b handshake ready
// v_bus_data_o         out  WD         vertical bus to PE column
// h_bus_data_o         out  WD         horizontal bus to PE column
// wire_connection_o    out  2          PE mode: 0 load,1 acc,2 shift-down,3 format/zero
// output_en_o          out  1          PE bottom-output select (1 = PE result)
// bot_data_i           in   WD         bottom tile output of column
// res_data_o           out  WD         drained result
// res_valid_o          out  1          res_data_o valid (no backpressure)
// BEHAVIOUR
// - Reset (async, rst_n=0): state IDLE, all counters 0; busy_o,done_o,a_ready_o,
//   b_ready_o,output_en_o,res_valid_o=0; v/h_bus,res_data=0; wire_connection_o=3.
//   Reset mid-job abandons job; no done_o. All outputs registered.
// - IDLE: wire_connection_o=3, buses 0. start_i=1 -> LOAD; latch k=max(k_len_i,1).
// - Operand fire = a_valid_i & b_valid_i & state in {LOAD,ACC}; a_ready_o=b_ready_o
//   = both valid & state in {LOAD,ACC} & steps remaining>0 (joint consume, never one).
// - LOAD: waits for fire; on fire next cycle drives code 0, v_bus=a, h_bus=b;
//   steps_left=k-1; ->ACC if steps_left>0 else ->FORMAT.
// - ACC: on fire drives code 1, h_bus=b, v_bus=0, steps_left-=1; no fire (bubble)
//   drives code 1 with h_bus=0 (zero product, accumulator unchanged). steps_left==0
//   after fire -> FORMAT.
// - FORMAT: code 3, buses 0, for exactly FMT_CYCLES cycles -> DRAIN.
// - DRAIN: code 2, output_en_o=1, buses 0. Capture bot_data_i into res_data_o with
//   res_valid_o=1 on DRAIN cycles PIPE_LAT .. PIPE_LAT+NUM_ROWS-1 (counted from
//   first DRAIN cycle at port); exactly NUM_ROWS results, in bottom-to-top order.
//   After last capture -> DONE.
// - DONE: done_o=1 one cycle, busy_o=0 next cycle, code 3, -> IDLE.
// - start_i while busy ignored (not queued). start_i in DONE cycle ignored.
// - Counters saturate-free: steps_left width WIDTH_CNT, drain counter
//   $clog2(NUM_ROWS+PIPE_LAT)+1; k_len_i=0 behaves as 1.
// - Min job latency (operands always valid): 1+k+FMT_CYCLES+PIPE_LAT+NUM_ROWS+1 cycles
//   from start_i to done_o.
// TESTING
// - Reset mid-ACC (k=8, after 3 fires): outputs return to reset values async,
//   wire_connection_o=3, no done_o; next start runs full job cleanly.
// - k=3, a=1,2,3 b=4,5,6 always valid: codes 0,1,1,3,3,2x6; h_bus 4,5,6; done_o at
//   cycle 1+3+2+2+4+1=13 after start.
// - k=4, b_valid_i low 2 cycles mid-ACC: exactly 2 bubbles (code 1, h_bus=0), 4 fires
//   total, ready never high without both valids.
// - Drain: model returns bot_data_i=0xA0+i at DRAIN cycle i: res_valid_o on 4 cycles
//   with data 0xA2,0xA3,0xA4,0xA5.
// - k_len_i=0 -> one LOAD fire, straight to FORMAT; start_i pulsed while busy: ignored.

Source files
------------

// File: rtl/pe_array_ctrl_if.sv
// Operand streams, job control and PE-column command bundle for pe_array_ctrl.
// The controller connects through the slave modport; the driving side uses master.
interface pe_array_ctrl_if #(
    parameter int WIDTH_DATA = 16,
    parameter int WIDTH_CNT  = 8
);
    logic                  start_i;
    logic [WIDTH_CNT-1:0]  k_len_i;
    logic                  busy_o;
    logic                  done_o;

    logic [WIDTH_DATA-1:0] a_data_i;
    logic                  a_valid_i;
    logic                  a_ready_o;
    logic [WIDTH_DATA-1:0] b_data_i;
    logic                  b_valid_i;
    logic                  b_ready_o;

    logic [WIDTH_DATA-1:0] v_bus_data_o;
    logic [WIDTH_DATA-1:0] h_bus_data_o;
    logic [1:0]            wire_connection_o;
    logic                  output_en_o;
    logic [WIDTH_DATA-1:0] bot_data_i;

    logic [WIDTH_DATA-1:0] res_data_o;
    logic                  res_valid_o;

    modport slave (
        input  start_i, k_len_i,
        input  a_data_i, a_valid_i, b_data_i, b_valid_i,
        input  bot_data_i,
        output busy_o, done_o,
        output a_ready_o, b_ready_o,
        output v_bus_data_o, h_bus_data_o, wire_connection_o, output_en_o,
        output res_data_o, res_valid_o
    );

    modport master (
        output start_i, k_len_i,
        output a_data_i, a_valid_i, b_data_i, b_valid_i,
        output bot_data_i,
        input  busy_o, done_o,
        input  a_ready_o, b_ready_o,
        input  v_bus_data_o, h_bus_data_o, wire_connection_o, output_en_o,
        input  res_data_o, res_valid_o
    );
endinterface

// File: rtl/pe_array_ctrl.sv
// Column sequencer for a NUM_ROWS-deep PE column: load, K MAC steps, format,
// then drain NUM_ROWS results from the bottom tile; all command outputs registered.
module pe_array_ctrl #(
    parameter int WIDTH_DATA = 16,
    parameter int NUM_ROWS   = 4,
    parameter int WIDTH_CNT  = 8,
    parameter int FMT_CYCLES = 2,
    parameter int PIPE_LAT   = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    pe_array_ctrl_if.slave  io
);
    localparam int DRN_W = $clog2(NUM_ROWS + PIPE_LAT) + 1;
    localparam int FMT_W = (FMT_CYCLES > 1) ? $clog2(FMT_CYCLES) : 1;

    localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(PIPE_LAT + NUM_ROWS);
    localparam logic [DRN_W-1:0] DRN_CAP0 = DRN_W'(PIPE_LAT + 1);
    localparam logic [FMT_W-1:0] FMT_LAST = FMT_W'(FMT_CYCLES - 1);

    localparam logic [1:0] WC_LOAD  = 2'd0;
    localparam logic [1:0] WC_ACC   = 2'd1;
    localparam logic [1:0] WC_SHIFT = 2'd2;
    localparam logic [1:0] WC_FMT   = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ACC,
        S_FORMAT,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [WIDTH_CNT-1:0]  steps_q, steps_d;
    logic [FMT_W-1:0]      fmt_cnt_q, fmt_cnt_d;
    logic [DRN_W-1:0]      drn_cnt_q, drn_cnt_d;

    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [1:0]            wc_q, wc_d;
    logic                  oe_q, oe_d;
    logic [WIDTH_DATA-1:0] v_bus_q, v_bus_d;
    logic [WIDTH_DATA-1:0] h_bus_q, h_bus_d;
    logic [WIDTH_DATA-1:0] res_data_q, res_data_d;
    logic                  res_valid_q, res_valid_d;

    logic                  operand_phase;
    logic                  fire;

    // A zero-length job still needs one load step to clear the accumulators.
    function automatic logic [WIDTH_CNT-1:0] clamp_k(input logic [WIDTH_CNT-1:0] k);
        return (k == '0) ? WIDTH_CNT'(1) : k;
    endfunction

    // Ready is gated by both valids so a and b are only ever consumed together.
    assign operand_phase = ((state_q == S_LOAD) || (state_q == S_ACC)) && (steps_q != '0);
    assign fire          = io.a_valid_i && io.b_valid_i && operand_phase;

    always_comb begin
        state_d     = state_q;
        steps_d     = steps_q;
        fmt_cnt_d   = fmt_cnt_q;
        drn_cnt_d   = drn_cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        wc_d        = WC_FMT;
        oe_d        = 1'b0;
        v_bus_d     = '0;
        h_bus_d     = '0;
        res_valid_d = 1'b0;
        res_data_d  = res_data_q;

        case (state_q)
            S_IDLE: begin
                if (io.start_i) begin
                    state_d = S_LOAD;
                    busy_d  = 1'b1;
                    steps_d = clamp_k(io.k_len_i);
                end
            end

            S_LOAD: begin
                if (fire) begin
                    wc_d      = WC_LOAD;
                    v_bus_d   = io.a_data_i;
                    h_bus_d   = io.b_data_i;
                    steps_d   = steps_q - WIDTH_CNT'(1);
                    fmt_cnt_d = '0;
                    state_d   = (steps_q == WIDTH_CNT'(1)) ? S_FORMAT : S_ACC;
                end
            end

            // A bubble still issues an accumulate, with a zero operand on h_bus.
            S_ACC: begin
                wc_d = WC_ACC;
                if (fire) begin
                    h_bus_d = io.b_data_i;
                    steps_d = steps_q - WIDTH_CNT'(1);
                    if (steps_q == WIDTH_CNT'(1)) begin
                        state_d   = S_FORMAT;
                        fmt_cnt_d = '0;
                    end
                end
            end

            S_FORMAT: begin
                if (fmt_cnt_q == FMT_LAST) begin
                    state_d   = S_DRAIN;
                    drn_cnt_d = '0;
                end else begin
                    fmt_cnt_d = fmt_cnt_q + FMT_W'(1);
                end
            end

            // Commands lead the port by one cycle and bot_data_i trails them by
            // PIPE_LAT, so captures run one count later than the drain index.
            S_DRAIN: begin
                if (drn_cnt_q >= DRN_CAP0) begin
                    res_valid_d = 1'b1;
                    res_data_d  = io.bot_data_i;
                end
                if (drn_cnt_q == DRN_LAST) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    wc_d      = WC_SHIFT;
                    oe_d      = 1'b1;
                    drn_cnt_d = drn_cnt_q + DRN_W'(1);
                end
            end

            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            steps_q     <= '0;
            fmt_cnt_q   <= '0;
            drn_cnt_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wc_q        <= WC_FMT;
            oe_q        <= 1'b0;
            v_bus_q     <= '0;
            h_bus_q     <= '0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            steps_q     <= steps_d;
            fmt_cnt_q   <= fmt_cnt_d;
            drn_cnt_q   <= drn_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            wc_q        <= wc_d;
            oe_q        <= oe_d;
            v_bus_q     <= v_bus_d;
            h_bus_q     <= h_bus_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign io.a_ready_o         = fire;
    assign io.b_ready_o         = fire;
    assign io.busy_o            = busy_q;
    assign io.done_o            = done_q;
    assign io.wire_connection_o = wc_q;
    assign io.output_en_o       = oe_q;
    assign io.v_bus_data_o      = v_bus_q;
    assign io.h_bus_data_o      = h_bus_q;
    assign io.res_data_o        = res_data_q;
    assign io.res_valid_o       = res_valid_q;
endmodule

// File: tb/tb_pe_array_ctrl.sv
// Bench for pe_array_ctrl: a cycle table for the k=3 job, directed multi-cycle
// sequences, and randomized jobs checked against a job-level trace model.
module tb_pe_array_ctrl;
    localparam int WD   = 16;
    localparam int NR   = 4;
    localparam int WC   = 8;
    localparam int FMT  = 2;
    localparam int PL   = 2;
    localparam int MAXC = 4000;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    pe_array_ctrl_if #(.WIDTH_DATA(WD), .WIDTH_CNT(WC)) io();

    pe_array_ctrl #(
        .WIDTH_DATA(WD), .NUM_ROWS(NR), .WIDTH_CNT(WC),
        .FMT_CYCLES(FMT), .PIPE_LAT(PL)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io)
    );

    typedef struct packed {
        logic        busy;
        logic        done;
        logic [1:0]  code;
        logic        oe;
        logic [15:0] v;
        logic [15:0] h;
        logic        rv;
        logic [15:0] rd;
    } obs_t;

    typedef struct {
        bit          start;
        bit          av;
        bit          bv;
        logic [15:0] a;
        logic [15:0] b;
        bit          rdy;
        obs_t        want;
    } vec_t;

    typedef enum int {EV_WAIT, EV_FIRST, EV_ACC, EV_BUBBLE} ev_t;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] bot_base = 16'h00A0;
    int          drain_i  = 0;
    ev_t         ev_kind [MAXC];
    logic [15:0] ev_a    [MAXC];
    logic [15:0] ev_b    [MAXC];
    vec_t        tbl     [15];

    // Column model: bottom tile presents base+i on the i-th shift-down cycle seen at the port.
    always @(negedge clk) begin
        if (io.wire_connection_o == 2'd2 && io.output_en_o) begin
            io.bot_data_i = bot_base + 16'(drain_i);
            drain_i++;
        end else begin
            drain_i = 0;
            io.bot_data_i = 16'h5A5A;
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, got, want);
    endtask

    task automatic cmp_obs(input string name, input obs_t got, input obs_t want);
        if (!want.rv) begin
            got.rd  = '0;
            want.rd = '0;
        end
        check(name, 64'(got), 64'(want));
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.busy = io.busy_o;            o.done = io.done_o;
        o.code = io.wire_connection_o; o.oe   = io.output_en_o;
        o.v    = io.v_bus_data_o;      o.h    = io.h_bus_data_o;
        o.rv   = io.res_valid_o;       o.rd   = io.res_data_o;
        return o;
    endfunction

    function automatic obs_t mk_obs(input bit busy, input bit done, input int code, input bit oe,
                                    input int v, input int h, input bit rv, input int rd);
        obs_t o;
        o.busy = busy; o.done = done; o.code = 2'(code); o.oe = oe;
        o.v = 16'(v);  o.h = 16'(h);  o.rv = rv;         o.rd = 16'(rd);
        return o;
    endfunction

    function automatic vec_t mkrow(input bit st, input bit av, input bit bv, input int a, input int b,
                                   input bit rdy, input obs_t want);
        vec_t r;
        r.start = st; r.av = av; r.bv = bv; r.a = 16'(a); r.b = 16'(b);
        r.rdy = rdy;  r.want = want;
        return r;
    endfunction

    task automatic drive(input bit st, input bit av, input bit bv,
                         input logic [15:0] a, input logic [15:0] b, input logic [7:0] k);
        io.start_i   = st;
        io.a_valid_i = av;
        io.b_valid_i = bv;
        io.a_data_i  = a;
        io.b_data_i  = b;
        io.k_len_i   = k;
    endtask

    // Expected outputs at cycle t after start, from the operand event log and
    // the cycle of the last operand fire (cf, -1 while still collecting).
    function automatic obs_t expect_at(input int t, input int cf);
        obs_t e;
        int   d0;
        int   i;
        e = mk_obs(1, 0, 3, 0, 0, 0, 0, 0);
        d0 = cf + 2 + FMT;
        if (cf < 0 || t <= cf + 1) begin
            if (t >= 2) begin
                case (ev_kind[t-1])
                    EV_FIRST:  begin e.code = 2'd0; e.v = ev_a[t-1]; e.h = ev_b[t-1]; end
                    EV_ACC:    begin e.code = 2'd1; e.h = ev_b[t-1]; end
                    EV_BUBBLE: e.code = 2'd1;
                    default:   ;
                endcase
            end
        end else if (t >= d0 && t < d0 + PL + NR) begin
            e.code = 2'd2;
            e.oe   = 1'b1;
            i = t - d0;
            if (i >= PL + 1) begin
                e.rv = 1'b1;
                e.rd = bot_base + 16'(i - 1);
            end
        end else if (t == d0 + PL + NR) begin
            e.done = 1'b1;
            e.rv   = 1'b1;
            e.rd   = bot_base + 16'(PL + NR - 1);
        end else if (t == d0 + PL + NR + 1) begin
            e.busy = 1'b0;
        end
        return e;
    endfunction

    task automatic run_job(input string tag, input int k_len, input int pv, input int gap_s,
                           input int gap_n, input bit pulse,
                           output int n0, output int n1, output int nbub);
        int          k, fires, cf, t, t_end, t_done;
        bit          av, bv, fire, st, fin;
        logic [15:0] ad, bd;
        obs_t        o, w;
        k = (k_len == 0) ? 1 : k_len;
        fires = 0; cf = -1; t = 0; t_end = -1; t_done = -1; fin = 1'b0;
        n0 = 0; n1 = 0; nbub = 0;
        bot_base = 16'($urandom_range(0, 65535));
        while (!fin) begin
            st = (t == 0) ? 1'b1 : (pulse && ($urandom_range(0, 3) == 0));
            av = ($urandom_range(0, 99) < pv);
            bv = ($urandom_range(0, 99) < pv);
            if (t >= gap_s && t < gap_s + gap_n) bv = 1'b0;
            ad = 16'($urandom);
            bd = 16'($urandom_range(1, 65535));
            drive(st, av, bv, ad, bd, 8'(k_len));
            fire = av && bv && (t >= 1) && (fires < k);
            #1;
            check($sformatf("%s ready t=%0d", tag, t), 64'({io.a_ready_o, io.b_ready_o}), 64'({fire, fire}));
            if (fire) ev_kind[t] = (fires == 0) ? EV_FIRST : EV_ACC;
            else      ev_kind[t] = (t >= 1 && fires > 0 && fires < k) ? EV_BUBBLE : EV_WAIT;
            ev_a[t] = ad;
            ev_b[t] = bd;
            if (fire) begin
                fires++;
                if (fires == k) begin
                    cf    = t;
                    t_end = cf + 3 + FMT + PL + NR;
                end
            end
            @(posedge clk); #1;
            t++;
            o = sample();
            w = expect_at(t, cf);
            cmp_obs($sformatf("%s out t=%0d", tag, t), o, w);
            if (o.done && t_done < 0) t_done = t;
            if (o.code == 2'd0) n0++;
            if (o.code == 2'd1) begin
                n1++;
                if (o.h == 16'd0 && o.v == 16'd0) nbub++;
            end
            if (t == t_end) fin = 1'b1;
            else if (t >= MAXC - 1) begin
                check($sformatf("%s timeout", tag), 64'(t), 64'(t_end));
                fin = 1'b1;
            end
        end
        check($sformatf("%s done latency", tag), 64'(t_done), 64'(cf + 2 + FMT + PL + NR));
        drive(0, 0, 0, 16'd0, 16'd0, 8'd0);
    endtask

    initial begin
        int   n0, n1, nb;
        obs_t rst_obs;

        // k=3, a=1,2,3 b=4,5,6, operands always valid; start re-pulsed in FORMAT and DONE.
        tbl[0]  = mkrow(1, 1, 1, 1, 4, 0, mk_obs(1, 0, 3, 0, 0, 0, 0, 0));
        tbl[1]  = mkrow(0, 1, 1, 1, 4, 1, mk_obs(1, 0, 0, 0, 1, 4, 0, 0));
        tbl[2]  = mkrow(0, 1, 1, 2, 5, 1, mk_obs(1, 0, 1, 0, 0, 5, 0, 0));
        tbl[3]  = mkrow(0, 1, 1, 3, 6, 1, mk_obs(1, 0, 1, 0, 0, 6, 0, 0));
        tbl[4]  = mkrow(0, 1, 1, 7, 8, 0, mk_obs(1, 0, 3, 0, 0, 0, 0, 0));
        tbl[5]  = mkrow(1, 1, 1, 7, 8, 0, mk_obs(1, 0, 3, 0, 0, 0, 0, 0));
        tbl[6]  = mkrow(0, 1, 1, 7, 8, 0, mk_obs(1, 0, 2, 1, 0, 0, 0, 0));
        tbl[7]  = mkrow(0, 1, 1, 7, 8, 0, mk_obs(1, 0, 2, 1, 0, 0, 0, 0));
        tbl[8]  = mkrow(0, 1, 1, 7, 8, 0, mk_obs(1, 0, 2, 1, 0, 0, 0, 0));
        tbl[9]  = mkrow(0, 1, 1, 7, 8, 0, mk_obs(1, 0, 2, 1, 0, 0, 1, 'hA2));
        tbl[10] = mkrow(0, 1, 1, 7, 8, 0, mk_obs(1, 0, 2, 1, 0, 0, 1, 'hA3));
        tbl[11] = mkrow(0, 1, 1, 7, 8, 0, mk_obs(1, 0, 2, 1, 0, 0, 1, 'hA4));
        tbl[12] = mkrow(0, 1, 1, 7, 8, 0, mk_obs(1, 1, 3, 0, 0, 0, 1, 'hA5));
        tbl[13] = mkrow(1, 1, 1, 7, 8, 0, mk_obs(0, 0, 3, 0, 0, 0, 0, 0));
        tbl[14] = mkrow(0, 1, 1, 7, 8, 0, mk_obs(0, 0, 3, 0, 0, 0, 0, 0));
        rst_obs = mk_obs(0, 0, 3, 0, 0, 0, 0, 0);

        drive(0, 0, 0, 16'd0, 16'd0, 8'd0);
        #1 rst_n = 1'b0;
        #1;
        cmp_obs("reset outputs", sample(), rst_obs);
        check("reset res_data", 64'(io.res_data_o), 64'd0);
        check("reset ready", 64'({io.a_ready_o, io.b_ready_o}), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        bot_base = 16'h00A0;
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].start, tbl[i].av, tbl[i].bv, tbl[i].a, tbl[i].b, 8'd3);
            #1;
            check($sformatf("vec%0d ready", i), 64'({io.a_ready_o, io.b_ready_o}),
                  64'({tbl[i].rdy, tbl[i].rdy}));
            @(posedge clk); #1;
            cmp_obs($sformatf("vec%0d out", i), sample(), tbl[i].want);
        end

        run_job("gap", 4, 100, 3, 2, 1'b0, n0, n1, nb);
        check("gap bubbles", 64'(nb), 64'd2);
        check("gap load steps", 64'(n0), 64'd1);
        check("gap acc cycles", 64'(n1), 64'd5);

        run_job("k0", 0, 100, 0, 0, 1'b1, n0, n1, nb);
        check("k0 load steps", 64'(n0), 64'd1);
        check("k0 acc cycles", 64'(n1), 64'd0);

        // Abandon a k=8 job after three operand fires.
        drive(1, 1, 1, 16'd1, 16'd1, 8'd8);
        @(posedge clk); #1;
        drive(0, 1, 1, 16'd2, 16'd2, 8'd8);
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("midacc code", 64'(io.wire_connection_o), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        cmp_obs("midacc reset outputs", sample(), rst_obs);
        check("midacc reset res_data", 64'(io.res_data_o), 64'd0);
        check("midacc reset ready", 64'({io.a_ready_o, io.b_ready_o}), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            cmp_obs($sformatf("midacc held %0d", i), sample(), rst_obs);
        end
        @(negedge clk) rst_n = 1'b1;
        drive(0, 0, 0, 16'd0, 16'd0, 8'd0);
        @(posedge clk); #1;
        cmp_obs("midacc released", sample(), rst_obs);
        run_job("post-rst", 8, 100, 0, 0, 1'b1, n0, n1, nb);
        check("post-rst acc cycles", 64'(n1), 64'd7);

        for (int j = 0; j < 16; j++) begin
            run_job($sformatf("rnd%0d", j), int'($urandom_range(0, 12)), int'($urandom_range(40, 100)),
                    0, 0, 1'b1, n0, n1, nb);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
